// File: rtl/v_sched.sv
// v_sched: registered DMA channel scheduler, 2-bit priority with round-robin inside each level.
// Optional starvation aging is enabled by defining V_SCHED_AGING_EN.
module v_sched #(
    parameter int unsigned CHANNEL_NUM = 4,
    parameter int unsigned AGE_W       = 4,
    parameter int unsigned AGE_LIMIT   = 8,
    localparam int unsigned IdW        = $clog2(CHANNEL_NUM)
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic [CHANNEL_NUM-1:0]   ch_enable_i,
    input  logic [2*CHANNEL_NUM-1:0] ch_prior_i,
    input  logic [CHANNEL_NUM-1:0]   req_i,
    output logic                     gnt_valid_o,
    output logic [IdW-1:0]           gnt_id_o,
    output logic [CHANNEL_NUM-1:0]   gnt_o,
    input  logic                     eng_ready_i,
    input  logic                     eng_done_i,
    input  logic                     eng_err_i,
    output logic                     err_valid_o,
    output logic [IdW-1:0]           err_ch_o,
    output logic                     busy_o
);

    if (CHANNEL_NUM < 2) begin : g_bad_channel_num
        $error("CHANNEL_NUM must be at least 2");
    end
    if (AGE_LIMIT >= (64'd1 << AGE_W)) begin : g_bad_age_limit
        $error("AGE_LIMIT must fit in AGE_W bits");
    end

    typedef enum logic [1:0] {StIdle, StArb, StGrant, StWaitDone} state_e;

    state_e                 state_q;
    logic [IdW-1:0]         ptr_q;
    logic [CHANNEL_NUM-1:0] elig;
    logic [1:0]             ep [CHANNEL_NUM];
    logic                   win_found;
    logic [IdW-1:0]         win_id;
    logic [1:0]             win_pr;
    logic [CHANNEL_NUM-1:0] win_onehot;
    int unsigned            scan_idx;
    logic [IdW-1:0]         scan_sel;

    assign elig   = req_i & ch_enable_i;
    assign busy_o = (state_q != StIdle);

`ifdef V_SCHED_AGING_EN
    logic [AGE_W-1:0] age_q [CHANNEL_NUM];

    always_comb begin
        for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
            ep[i] = (age_q[i] == AGE_W'(AGE_LIMIT)) ? 2'd3 : ch_prior_i[2*i +: 2];
        end
    end

    // A channel ages only while it keeps requesting and keeps losing arbitration.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int unsigned i = 0; i < CHANNEL_NUM; i++) age_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
                if (!elig[i]) begin
                    age_q[i] <= '0;
                end else if (state_q == StGrant && eng_ready_i && gnt_id_o == IdW'(i)) begin
                    age_q[i] <= '0;
                end else if (state_q == StArb && win_found && win_id != IdW'(i) &&
                             age_q[i] != AGE_W'(AGE_LIMIT)) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < CHANNEL_NUM; i++) ep[i] = ch_prior_i[2*i +: 2];
    end
`endif

    // Circular scan from ptr+1; a strictly higher priority is needed to displace an earlier hit.
    always_comb begin
        win_found  = 1'b0;
        win_id     = '0;
        win_pr     = '0;
        win_onehot = '0;
        scan_idx   = 0;
        scan_sel   = '0;
        for (int unsigned k = 1; k <= CHANNEL_NUM; k++) begin
            scan_idx = 32'(ptr_q) + k;
            if (scan_idx >= CHANNEL_NUM) scan_idx = scan_idx - CHANNEL_NUM;
            scan_sel = IdW'(scan_idx);
            if (elig[scan_sel] && (!win_found || ep[scan_sel] > win_pr)) begin
                win_found = 1'b1;
                win_id    = scan_sel;
                win_pr    = ep[scan_sel];
            end
        end
        win_onehot[win_id] = win_found;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= StIdle;
            gnt_valid_o <= 1'b0;
            gnt_id_o    <= '0;
            gnt_o       <= '0;
            err_valid_o <= 1'b0;
            err_ch_o    <= '0;
            ptr_q       <= IdW'(CHANNEL_NUM - 1);
        end else begin
            err_valid_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|elig) state_q <= StArb;
                end
                StArb: begin
                    if (win_found) begin
                        gnt_id_o    <= win_id;
                        gnt_o       <= win_onehot;
                        gnt_valid_o <= 1'b1;
                        state_q     <= StGrant;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StGrant: begin
                    if (eng_ready_i) begin
                        gnt_valid_o <= 1'b0;
                        state_q     <= StWaitDone;
                    end else if (!elig[gnt_id_o]) begin
                        gnt_valid_o <= 1'b0;
                        gnt_o       <= '0;
                        state_q     <= StArb;
                    end
                end
                StWaitDone: begin
                    if (eng_done_i) begin
                        ptr_q <= gnt_id_o;
                        gnt_o <= '0;
                        if (eng_err_i) begin
                            err_valid_o <= 1'b1;
                            err_ch_o    <= gnt_id_o;
                        end
                        state_q <= (|elig) ? StArb : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
